// File: rtl/bpu_update_gen.sv
// bpu_update_gen: tracks in-flight fetch packet predictions in an in-order
// queue, compares them against backend resolutions and emits a registered
// one-cycle flush with the corrected fetch target to the PC generator.
// Optional build macro: BPU_UPDATE_STAT_EN adds resolve/mispredict counters.
// Handshake: a fetch packet is accepted on any cycle with fetch_valid_i=1 and
// stall_o=0 and no flush being generated; resolve/redirect are single-cycle
// strobes with no back-pressure.

package bpu_update_pkg;
  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
  } bpu_predict_t;

  typedef struct packed {
    logic        flush;
    logic [29:0] br_target;
    logic        btb_we;
    logic [29:0] btb_pc;
    logic        ras_push;
    logic        ras_pop;
  } bpu_update_t;
endpackage

module bpu_update_gen
  import bpu_update_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_valid_i,
  input  logic [31:0]  fetch_pc_i,
  input  bpu_predict_t predict_i,
  input  logic         resolve_valid_i,
  input  logic         resolve_taken_i,
  input  logic [31:0]  resolve_target_i,
  input  logic         redirect_valid_i,
  input  logic [31:0]  redirect_target_i,
  output bpu_update_t  update_o,
  output logic         stall_o,
  output logic         err_o
`ifdef BPU_UPDATE_STAT_EN
  ,
  output logic [31:0]  stat_resolve_o,
  output logic [31:0]  stat_mispredict_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [28:0]   pc_mem_q  [DEPTH];
  logic [29:0]   npc_mem_q [DEPTH];
  bpu_update_t   update_q, update_d;
  logic          err_q, err_d;

  logic          full, empty;
  logic          resolve_ok, mispredict, clear, pop, push;
  logic [28:0]   head_pc;
  logic [29:0]   head_npc;
  logic [31:0]   actual;

  // Bits below the packet/word alignment carry no information here.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc_i[2:0], predict_i.taken, predict_i.npc[1:0],
                         resolve_target_i[1:0], redirect_target_i[1:0]};

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Head compare, event priority (redirect > resolve > push) and next state.
  always_comb begin
    head_pc    = pc_mem_q[rd_ptr_q[AW-1:0]];
    head_npc   = npc_mem_q[rd_ptr_q[AW-1:0]];
    actual     = resolve_taken_i ? resolve_target_i : {head_pc + 29'd1, 3'b000};
    mispredict = (actual[31:2] != head_npc);
    resolve_ok = resolve_valid_i && !empty && !redirect_valid_i;
    clear      = redirect_valid_i || (resolve_ok && mispredict);
    pop        = resolve_ok && !mispredict;
    push       = fetch_valid_i && !full && !clear;

    update_d = '0;
    if (redirect_valid_i) begin
      update_d.flush     = 1'b1;
      update_d.br_target = redirect_target_i[31:2];
    end else if (resolve_ok && mispredict) begin
      update_d.flush     = 1'b1;
      update_d.br_target = actual[31:2];
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    err_d = err_q | (resolve_valid_i && empty && !redirect_valid_i);
  end

  // Pointers, registered flush and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      update_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  // Entry storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q[AW-1:0]]  <= fetch_pc_i[31:3];
      npc_mem_q[wr_ptr_q[AW-1:0]] <= predict_i.npc[31:2];
    end
  end

  assign update_o = update_q;
  assign stall_o  = full;
  assign err_o    = err_q;

`ifdef BPU_UPDATE_STAT_EN
  logic [31:0] stat_resolve_q, stat_mispredict_q;

  // Saturating counters of non-empty resolves and of mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolve_q    <= '0;
      stat_mispredict_q <= '0;
    end else begin
      if (resolve_ok && (stat_resolve_q != 32'hFFFF_FFFF))
        stat_resolve_q <= stat_resolve_q + 32'd1;
      if (resolve_ok && mispredict && (stat_mispredict_q != 32'hFFFF_FFFF))
        stat_mispredict_q <= stat_mispredict_q + 32'd1;
    end
  end

  assign stat_resolve_o    = stat_resolve_q;
  assign stat_mispredict_o = stat_mispredict_q;
`endif

endmodule
